alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 22 ++
 rtl/alu_pipe_core.sv | 102 ++++++++++
 rtl/alu_pipe.sv | 117 +++++++++++
 tb/tb_alu_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared processing-unit types.
// Holds the ALU operation encoding used across the pipeline.
package Pu_types;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NEG,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NAND,
    ALU_NOR,
    ALU_ROTL,
    ALU_ESH,
    ALU_ESB,
    ALU_SHL,
    ALU_SHR,
    ALU_SRA
  } Alu_op;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU: result, carry/overflow and signed compare flags.
// Pure datapath; the pipeline wrapper registers its outputs.
module alu_core
  import Pu_types::*;
#(
  parameter int WIDTH = 32
) (
  input  Alu_op                      i_op,
  input  logic [WIDTH-1:0]           i_a,
  input  logic [WIDTH-1:0]           i_b,
  input  logic                       i_cin,
  input  logic [$clog2(WIDTH)-1:0]   i_dist,
  input  logic [$clog2(WIDTH)-1:0]   i_start,
  input  logic [$clog2(WIDTH)-1:0]   i_stop,
  output logic [WIDTH-1:0]           o_res,
  output logic                       o_cout,
  output logic                       o_ov,
  output logic                       o_lt,
  output logic                       o_gt,
  output logic                       o_eq
);

  localparam int HW = (WIDTH < 16) ? WIDTH : 16;

  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic               w_c;
  logic [WIDTH-1:0]   w_sum;
  logic               w_co;
  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rot;
  logic [WIDTH-1:0]   w_mask;
  logic               w_arith;

  // add, sub and neg share one adder: x + y + c
  always_comb begin
    w_x = i_a;
    w_y = i_b;
    w_c = i_cin;
    case (i_op)
      ALU_SUB: w_x = ~i_a;
      ALU_NEG: begin
        w_x = ~i_a;
        w_y = '0;
        w_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign {w_co, w_sum} = {1'b0, w_x}
                       + {1'b0, w_y}
                       + {{WIDTH{1'b0}}, w_c};

  assign w_dbl = {i_a, i_a} << i_dist;
  assign w_rot = w_dbl[2*WIDTH-1:WIDTH];

  // mask positions count from the MSB (position 0)
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_start <= i_stop)
        w_mask[WIDTH-1-i] = (i >= int'(i_start))
                         && (i <= int'(i_stop));
      else
        w_mask[WIDTH-1-i] = (i >= int'(i_start))
                         || (i <= int'(i_stop));
    end
  end

  always_comb begin
    o_res   = w_sum;
    w_arith = 1'b0;
    case (i_op)
      ALU_ADD,
      ALU_SUB,
      ALU_NEG:  w_arith = 1'b1;
      ALU_AND:  o_res = i_a & i_b;
      ALU_OR:   o_res = i_a | i_b;
      ALU_XOR:  o_res = i_a ^ i_b;
      ALU_NAND: o_res = ~(i_a & i_b);
      ALU_NOR:  o_res = ~(i_a | i_b);
      ALU_ROTL: o_res = (w_rot & w_mask)
                      | (i_b & ~w_mask);
      ALU_ESH:  o_res = WIDTH'($signed(i_a[HW-1:0]));
      ALU_ESB:  o_res = WIDTH'($signed(i_a[7:0]));
      ALU_SHL:  o_res = i_a << i_dist;
      ALU_SHR:  o_res = i_a >> i_dist;
      ALU_SRA:  o_res = $unsigned($signed(i_a) >>> i_dist);
      default:  o_res = w_sum;
    endcase
  end

  assign o_cout = w_arith & w_co;
  assign o_ov   = w_arith
                & (w_x[WIDTH-1] == w_y[WIDTH-1])
                & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
  assign o_eq   = (o_res == '0);
  assign o_lt   = o_res[WIDTH-1];
  assign o_gt   = !o_eq && !o_lt;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU wrapper: STAGES register slices with valid/ready flow.
// Stage 1 captures the core result; later stages only move data.
module alu_pipe
  import Pu_types::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  Alu_op                     op,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      cin,
  input  logic [$clog2(WIDTH)-1:0]  rot_dist,
  input  logic [$clog2(WIDTH)-1:0]  rot_start,
  input  logic [$clog2(WIDTH)-1:0]  rot_stop,
  input  logic [TAG_W-1:0]          tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          res,
  output logic                      cout,
  output logic                      ov,
  output logic                      lt,
  output logic                      gt,
  output logic                      eq,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int L = STAGES - 1;

  if (!(WIDTH == 8 || WIDTH == 16 ||
        WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("alu_pipe: WIDTH must be 8, 16, 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_pipe: STAGES must be 1 to 4");
  end

  logic [WIDTH-1:0]  w_res;
  logic              w_cout;
  logic              w_ov;
  logic              w_lt;
  logic              w_gt;
  logic              w_eq;
  logic              w_acc;
  logic [STAGES-1:0] w_en;

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [4:0]        r_flg [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .i_dist  (rot_dist),
    .i_start (rot_start),
    .i_stop  (rot_stop),
    .o_res   (w_res),
    .o_cout  (w_cout),
    .o_ov    (w_ov),
    .o_lt    (w_lt),
    .o_gt    (w_gt),
    .o_eq    (w_eq)
  );

  // a stage moves when it or anything downstream has a hole
  for (genvar i = 0; i < STAGES; i++) begin : g_en
    assign w_en[i] = out_ready | !(&r_vld[STAGES-1:i]);
  end

  assign in_ready = !reset && (out_ready || !(|r_vld));
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_res[i] <= '0;
        r_flg[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      if (w_en[0]) begin
        r_vld[0] <= w_acc;
        if (w_acc) begin
          r_res[0] <= w_res;
          r_flg[0] <= {w_cout, w_ov, w_lt, w_gt, w_eq};
          r_tag[0] <= tag;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_en[i]) begin
          r_vld[i] <= r_vld[i-1];
          r_res[i] <= r_res[i-1];
          r_flg[i] <= r_flg[i-1];
          r_tag[i] <= r_tag[i-1];
        end
      end
    end
  end

  // idle output reads as a zero result, hence eq stays high
  assign out_valid = r_vld[L];
  assign res       = out_valid ? r_res[L] : '0;
  assign {cout, ov, lt, gt} =
    out_valid ? r_flg[L][4:1] : 4'b0;
  assign eq        = out_valid ? r_flg[L][0] : 1'b1;
  assign out_tag   = out_valid ? r_tag[L] : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at 8/1, 32/2 and 64/4.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_alu_pipe;
  import Pu_types::*;

  typedef struct {
    int          d;
    logic [63:0] r;
    logic [4:0]  f;
    logic [3:0]  t;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ordy = 1'b1;
  logic [2:0]  iv = '0;
  Alu_op       op_s = ALU_ADD;
  logic [63:0] a_s = '0;
  logic [63:0] b_s = '0;
  logic        cin_s = 1'b0;
  logic [5:0]  rd_s = '0;
  logic [5:0]  rs_s = '0;
  logic [5:0]  rp_s = '0;
  logic [3:0]  tag_s = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];

  int wd[3]  = '{8, 32, 64};
  int stg[3] = '{1, 2, 4};

  logic        ir8, ov8, co8, vf8, lt8, gt8, eq8;
  logic        ir32, ov32, co32, vf32, lt32, gt32, eq32;
  logic        ir64, ov64, co64, vf64, lt64, gt64, eq64;
  logic [7:0]  res8;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [3:0]  tg8, tg32, tg64;

  logic        w_ir[3];
  logic        w_ovld[3];
  logic [63:0] w_res[3];
  logic [4:0]  w_flg[3];
  logic [3:0]  w_tag[3];

  assign w_ir[0] = ir8;
  assign w_ir[1] = ir32;
  assign w_ir[2] = ir64;
  assign w_ovld[0] = ov8;
  assign w_ovld[1] = ov32;
  assign w_ovld[2] = ov64;
  assign w_res[0] = {56'b0, res8};
  assign w_res[1] = {32'b0, res32};
  assign w_res[2] = res64;
  assign w_flg[0] = {co8, vf8, lt8, gt8, eq8};
  assign w_flg[1] = {co32, vf32, lt32, gt32, eq32};
  assign w_flg[2] = {co64, vf64, lt64, gt64, eq64};
  assign w_tag[0] = tg8;
  assign w_tag[1] = tg32;
  assign w_tag[2] = tg64;

  alu_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u8 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir8),
    .op(op_s), .a(a_s[7:0]), .b(b_s[7:0]), .cin(cin_s),
    .rot_dist(rd_s[2:0]), .rot_start(rs_s[2:0]),
    .rot_stop(rp_s[2:0]), .tag(tag_s),
    .out_valid(ov8), .out_ready(ordy), .res(res8),
    .cout(co8), .ov(vf8), .lt(lt8), .gt(gt8), .eq(eq8),
    .out_tag(tg8));

  alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u32 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir32),
    .op(op_s), .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s),
    .rot_dist(rd_s[4:0]), .rot_start(rs_s[4:0]),
    .rot_stop(rp_s[4:0]), .tag(tag_s),
    .out_valid(ov32), .out_ready(ordy), .res(res32),
    .cout(co32), .ov(vf32), .lt(lt32), .gt(gt32), .eq(eq32),
    .out_tag(tg32));

  alu_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(4)) u64 (
    .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir64),
    .op(op_s), .a(a_s), .b(b_s), .cin(cin_s),
    .rot_dist(rd_s), .rot_start(rs_s),
    .rot_stop(rp_s), .tag(tag_s),
    .out_valid(ov64), .out_ready(ordy), .res(res64),
    .cout(co64), .ov(vf64), .lt(lt64), .gt(gt64), .eq(eq64),
    .out_tag(tg64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic send(input int d, input Alu_op o,
                      input logic [63:0] aa, input logic [63:0] bb,
                      input logic c, input int rd, input int rs,
                      input int rp, input logic [3:0] t,
                      input logic [63:0] er, input logic eco,
                      input logic eov, input bit lat);
    exp_t e;
    int n = 0;
    logic eeq, elt;
    @(negedge clk);
    op_s = o; a_s = aa; b_s = bb; cin_s = c;
    rd_s = 6'(rd); rs_s = 6'(rs); rp_s = 6'(rp);
    tag_s = t;
    iv[d] = 1'b1;
    while (!w_ir[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d tag=%h", d, t);
      iv[d] = 1'b0;
    end else begin
      eeq = (er == 64'd0);
      elt = er[wd[d]-1];
      e.d = d; e.r = er; e.t = t; e.acc = cyc; e.lat = lat;
      e.f = {eco, eov, elt, !eeq && !elt, eeq};
      q.push_back(e);
      @(posedge clk);
      #1 iv[d] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int d);
    chk($sformatf("idle_valid%0d", d), 64'(w_ovld[d]), 64'd0);
    chk($sformatf("idle_res%0d", d), w_res[d], 64'd0);
    chk($sformatf("idle_flags%0d", d), 64'(w_flg[d]), 64'b00001);
    chk($sformatf("idle_tag%0d", d), 64'(w_tag[d]), 64'd0);
  endtask

  bit          hold[3]  = '{0, 0, 0};
  bit          fresh[3] = '{1, 1, 1};
  int          t_first[3];
  logic [63:0] h_res[3];
  logic [4:0]  h_flg[3];
  logic [3:0]  h_tag[3];

  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        hold[d] = 0;
        fresh[d] = 1;
      end else begin
        if (hold[d]) begin
          chk($sformatf("stall_res%0d", d), w_res[d], h_res[d]);
          chk($sformatf("stall_ctl%0d", d),
              64'({w_ovld[d], w_flg[d], w_tag[d]}),
              64'({1'b1, h_flg[d], h_tag[d]}));
        end
        if (w_ovld[d]) begin
          if (fresh[d]) begin
            t_first[d] = cyc;
            fresh[d] = 0;
          end
          if (ordy) begin
            hold[d] = 0;
            fresh[d] = 1;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out dut%0d tag=%h res=%h",
                       d, w_tag[d], w_res[d]);
            end else begin
              e = q.pop_front();
              chk("out_dut", 64'(d), 64'(e.d));
              chk($sformatf("res_t%0h", e.t), w_res[d], e.r);
              chk($sformatf("flags_t%0h", e.t),
                  64'(w_flg[d]), 64'(e.f));
              chk("tag", 64'(w_tag[d]), 64'(e.t));
              if (e.lat)
                chk($sformatf("latency%0d", d),
                    64'(t_first[d] - e.acc), 64'(stg[d]));
            end
          end else begin
            hold[d] = 1;
            h_res[d] = w_res[d];
            h_flg[d] = w_flg[d];
            h_tag[d] = w_tag[d];
          end
        end else begin
          hold[d] = 0;
          fresh[d] = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready%0d", d), 64'(w_ir[d]), 64'd0);
      idle(d);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("post_rst_ready%0d", d), 64'(w_ir[d]), 64'd1);

    send(1, ALU_ADD, 64'h7fffffff, 64'h1, 0, 0, 0, 0, 4'h1,
         64'h80000000, 0, 1, 1);
    send(1, ALU_SUB, 64'h1, 64'h4, 1, 0, 0, 0, 4'h2,
         64'h3, 1, 0, 0);
    send(1, ALU_NEG, 64'h80000000, 64'h0, 0, 0, 0, 0, 4'h3,
         64'h80000000, 0, 1, 0);
    send(1, ALU_ROTL, 64'hffffdead, 64'h0000face, 0, 16, 0, 15,
         4'h4, 64'hdeadface, 0, 0, 0);
    send(1, ALU_ROTL, 64'hffffdead, 64'h0000face, 0, 16, 16, 15,
         4'h5, 64'hdeadffff, 0, 0, 0);
    send(1, ALU_ROTL, 64'h12345678, 64'h0, 0, 4, 8, 15,
         4'h6, 64'h00450000, 0, 0, 0);
    send(1, ALU_AND, 64'hf0f0f0f0, 64'hff00ff00, 0, 0, 0, 0,
         4'h7, 64'hf000f000, 0, 0, 0);
    send(1, ALU_XOR, 64'hf0f0f0f0, 64'hff00ff00, 0, 0, 0, 0,
         4'h8, 64'h0ff00ff0, 0, 0, 0);
    send(1, ALU_NOR, 64'h0, 64'h0, 0, 0, 0, 0,
         4'h9, 64'hffffffff, 0, 0, 0);
    send(1, ALU_NAND, 64'hffffffff, 64'hffffffff, 0, 0, 0, 0,
         4'ha, 64'h0, 0, 0, 0);
    send(1, ALU_OR, 64'h12340000, 64'h00005678, 0, 0, 0, 0,
         4'hb, 64'h12345678, 0, 0, 0);
    send(1, ALU_ESH, 64'h00008001, 64'h0, 0, 0, 0, 0,
         4'hc, 64'hffff8001, 0, 0, 0);
    send(1, ALU_ESB, 64'h0000007f, 64'h0, 0, 0, 0, 0,
         4'hd, 64'h0000007f, 0, 0, 0);
    send(1, ALU_SHL, 64'h1, 64'h0, 0, 31, 0, 0,
         4'he, 64'h80000000, 0, 0, 0);
    send(1, ALU_SHR, 64'h80000000, 64'h0, 0, 4, 0, 0,
         4'hf, 64'h08000000, 0, 0, 0);
    send(1, ALU_SRA, 64'h80000000, 64'h0, 0, 4, 0, 0,
         4'h0, 64'hf8000000, 0, 0, 0);
    send(1, ALU_ADD, 64'hffffffff, 64'h0, 1, 0, 0, 0,
         4'h1, 64'h0, 1, 0, 0);
    drain();
    idle(1);

    fork
      begin
        for (int i = 0; i < 6; i++)
          send(1, ALU_ADD, 64'(i * 16), 64'h1, 0, 0, 0, 0,
               4'(i), 64'(i * 16 + 1), 0, 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #2 ordy = 1'b0;
        repeat (4) @(posedge clk);
        #2 ordy = 1'b1;
      end
    join
    drain();

    send(1, ALU_ADD, 64'h1, 64'h1, 0, 0, 0, 0, 4'ha, 64'h2, 0, 0, 0);
    send(1, ALU_ADD, 64'h2, 64'h2, 0, 0, 0, 0, 4'hb, 64'h4, 0, 0, 0);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("in_ready_in_reset", 64'(ir32), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(1);
    chk("in_ready_after_reset", 64'(ir32), 64'd1);
    repeat (10) @(negedge clk);
    idle(1);

    send(0, ALU_ESB, 64'h7f, 64'h0, 0, 0, 0, 0, 4'h1,
         64'h7f, 0, 0, 1);
    send(0, ALU_ADD, 64'hff, 64'h1, 0, 0, 0, 0, 4'h2,
         64'h0, 1, 0, 0);
    send(0, ALU_SRA, 64'h80, 64'h0, 0, 7, 0, 0, 4'h3,
         64'hff, 0, 0, 0);
    drain();
    idle(0);

    send(2, ALU_SRA, 64'h8000_0000_0000_0000, 64'h0, 0, 63, 0, 0,
         4'h4, 64'hffff_ffff_ffff_ffff, 0, 0, 1);
    send(2, ALU_ADD, 64'h7fff_ffff_ffff_ffff, 64'h1, 0, 0, 0, 0,
         4'h5, 64'h8000_0000_0000_0000, 0, 1, 0);
    send(2, ALU_ROTL, 64'h0123_4567_89ab_cdef, 64'h0, 0, 8, 0, 63,
         4'h6, 64'h2345_6789_abcd_ef01, 0, 0, 0);
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
